sample_fifo: RTL and testbench

Memory-mapped transmit FIFO that sits directly behind the bus decoder in the DSP path. It takes the one-cycle `we`/`re` strobes, address and write data from the decoder, and buffers CPU-written samples. It drains them into the DSP pipeline over a valid/ready stream. Status, control and a refill-threshold interrupt are exposed to the CPU through four 32-bit registers.

---
 rtl/sample_fifo.sv | 171 +++++++++++++++++
 tb/tb_sample_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_fifo.sv
// sample_fifo
//   CPU-written transmit FIFO feeding the DSP pipeline over a valid/ready
//   stream. The bus decoder supplies one-cycle we/re strobes. Four 32-bit
//   registers are decoded on addr[3:2]:
//     0 DATA    write pushes wdata[WIDTH-1:0]; read returns 0
//     1 STATUS  [7:0] level, [8] empty, [9] full, [10] overflow, [11] underrun
//               (bits 10/11 sticky, write-1-to-clear)
//     2 CONTROL [0] en (r/w), [1] clr (write-only pulse)
//     3 THRESH  [LW-1:0] refill threshold
//
// Ports
//   ck       system clock, rising edge
//   rst_n    asynchronous active-low reset
//   we, re   single-cycle write/read strobes (we wins if both are high)
//   addr     byte offset, only [3:2] decoded
//   wdata    CPU write data
//   rdata    registered read data, valid the cycle after re
//   s_valid  head sample valid toward the DSP
//   s_ready  DSP accepts the head sample
//   s_data   head sample, 0 when empty
//   irq      registered refill request: en && level <= THRESH
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic              ck,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [3:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [WIDTH-1:0]  s_data,
    output logic              irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LW-1:0]    level;
    logic [LW-1:0]    thresh;
    logic             en;
    logic             ovf;
    logic             unf;

    logic [1:0]       reg_sel;
    logic             wr_data;
    logic             wr_status;
    logic             wr_ctrl;
    logic             wr_thresh;
    logic             rd;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             clr;
    logic [31:0]      rd_word;

    // Bits of the bus that no register field consumes.
    logic             unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};

    assign reg_sel   = addr[3:2];
    assign wr_data   = we && (reg_sel == 2'd0);
    assign wr_status = we && (reg_sel == 2'd1);
    assign wr_ctrl   = we && (reg_sel == 2'd2);
    assign wr_thresh = we && (reg_sel == 2'd3);
    // A read strobe colliding with a write strobe is dropped.
    assign rd        = re && !we;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // Fullness is judged on the start-of-cycle level, so a same-cycle pop
    // never makes room for a push.
    assign push = wr_data && !full;
    assign pop  = s_valid && s_ready;
    assign clr  = wr_ctrl && wdata[1];

    assign s_valid = en && !empty;
    assign s_data  = empty ? '0 : mem[rptr];

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            2'd1: begin
                rd_word[7:0] = 8'(level);
                rd_word[8]   = empty;
                rd_word[9]   = full;
                rd_word[10]  = ovf;
                rd_word[11]  = unf;
            end
            2'd2: rd_word[0] = en;
            2'd3: rd_word[LW-1:0] = thresh;
            default: rd_word = '0;
        endcase
    end

    // Sample storage carries no reset; s_data is masked while empty.
    always_ff @(posedge ck) begin
        if (push) begin
            mem[wptr] <= wdata[WIDTH-1:0];
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            level  <= '0;
            thresh <= '0;
            en     <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            irq    <= 1'b0;
            rdata  <= '0;
        end else begin
            // clr discards any pop happening in the same cycle.
            if (clr) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                if (push) begin
                    wptr <= wptr + AW'(1);
                end
                if (pop) begin
                    rptr <= rptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
            end

            if (wr_ctrl) begin
                en <= wdata[0];
            end
            if (wr_thresh) begin
                thresh <= wdata[LW-1:0];
            end

            // A new event in the same cycle as its clear keeps the flag set.
            if (wr_status && wdata[10]) begin
                ovf <= 1'b0;
            end
            if (wr_data && full) begin
                ovf <= 1'b1;
            end
            if (wr_status && wdata[11]) begin
                unf <= 1'b0;
            end
            if (en && s_ready && empty) begin
                unf <= 1'b1;
            end

            irq <= en && (level <= thresh);

            if (rd) begin
                rdata <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_sample_fifo.sv
module tb_sample_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic             ck = 1'b0;
    logic             rst_n = 1'b0;
    logic             we = 1'b0;
    logic             re = 1'b0;
    logic [3:0]       addr = '0;
    logic [31:0]      wdata = '0;
    logic [31:0]      rdata;
    logic             s_valid;
    logic             s_ready = 1'b0;
    logic [WIDTH-1:0] s_data;
    logic             irq;

    always #5 ck = ~ck;

    sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .ck      (ck),
        .rst_n   (rst_n),
        .we      (we),
        .re      (re),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .irq     (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the FIFO is a queue, registers are plain variables.
    logic [WIDTH-1:0] exp_q [$];
    logic [31:0]      rd_q [$];
    bit               m_en = 1'b0;
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;
    int               m_thresh = 0;
    bit               mon_en = 1'b0;
    bit               re_seen = 1'b0;
    bit               irq_exp = 1'b0;
    bit               irq_nxt;
    int               mon_sz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int lvl;
        logic [31:0] s;
        lvl = exp_q.size();
        s = '0;
        s[7:0] = lvl[7:0];
        s[8]   = (lvl == 0);
        s[9]   = (lvl == DEPTH);
        s[10]  = m_ovf;
        s[11]  = m_unf;
        return s;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        rd_q.delete();
        m_en = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_thresh = 0;
        irq_exp = 1'b0;
        re_seen = 1'b0;
    endtask

    // Each bus task starts just after a rising edge and ends just after the next.
    task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
        bit acc;
        acc = 1'b0;
        addr = {r, 2'b00};
        wdata = d;
        we = 1'b1;
        if (r == 2'd0) begin
            acc = (exp_q.size() < DEPTH);
            if (!acc) m_ovf = 1'b1;
        end
        if (r == 2'd1) begin
            if (d[10]) m_ovf = 1'b0;
            if (d[11]) m_unf = 1'b0;
        end
        @(posedge ck);
        #1;
        we = 1'b0;
        if (r == 2'd0 && acc) exp_q.push_back(d[WIDTH-1:0]);
        if (r == 2'd2) begin
            m_en = d[0];
            if (d[1]) exp_q.delete();
        end
        if (r == 2'd3) m_thresh = int'(d[LW-1:0]);
    endtask

    task automatic bus_read(input logic [1:0] r);
        logic [31:0] e;
        case (r)
            2'd1:    e = exp_status();
            2'd2:    e = {31'b0, m_en};
            2'd3:    e = 32'(m_thresh);
            default: e = '0;
        endcase
        rd_q.push_back(e);
        addr = {r, 2'b00};
        re = 1'b1;
        @(posedge ck);
        #1;
        re = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        bus_write(2'd0, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    // Monitor: compares every DUT output against the model in mid-cycle.
    always @(negedge ck) begin
        if (mon_en) begin
            if (re_seen) begin
                if (rd_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rdata: got 0x%0h, expected no read response", rdata);
                end else begin
                    check("rdata", rdata, rd_q.pop_front());
                end
            end
            re_seen = re && !we;

            mon_sz = exp_q.size();
            check("irq", irq, irq_exp);
            irq_nxt = m_en && (mon_sz <= m_thresh);
            check("s_valid", s_valid, m_en && (mon_sz != 0));
            check("s_data", s_data, (mon_sz != 0) ? exp_q[0] : '0);
            if (m_en && s_ready && mon_sz == 0) m_unf = 1'b1;
            if (m_en && s_ready && mon_sz != 0) exp_q.delete(0);
            irq_exp = irq_nxt;
        end
    end

    initial begin
        int k;
        logic [31:0] d;

        // Reset state
        #3;
        check("reset_rdata", rdata, 32'h0);
        check("reset_s_valid", s_valid, 1'b0);
        check("reset_s_data", s_data, '0);
        check("reset_irq", irq, 1'b0);
        @(posedge ck);
        #2;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge ck);
        #1;
        bus_read(2'd1);
        bus_read(2'd2);
        bus_read(2'd3);

        // Basic flow
        bus_write(2'd3, 32'd2);
        bus_write(2'd2, 32'd1);
        push(32'h1111);
        push(32'h2222);
        push(32'h3333);
        bus_read(2'd1);
        s_ready = 1'b1;
        idle(6);
        s_ready = 1'b0;
        bus_read(2'd1);
        bus_write(2'd1, 32'hC00);

        // Overflow with en=0
        bus_write(2'd2, 32'd0);
        for (int i = 0; i < 17; i++) push($urandom);
        bus_read(2'd1);
        bus_write(2'd1, 32'h400);
        bus_read(2'd1);

        // Full with concurrent pop
        s_ready = 1'b1;
        bus_write(2'd2, 32'd1);
        push($urandom);
        s_ready = 1'b0;
        bus_read(2'd1);
        s_ready = 1'b1;
        idle(17);
        s_ready = 1'b0;
        bus_write(2'd1, 32'h800);

        // Wrap-around
        for (int i = 0; i < 40; i++) begin
            push(32'(i));
            bus_read(2'd1);
            s_ready = 1'b1;
            idle(1);
            s_ready = 1'b0;
        end

        // Clear with concurrent pop
        for (int i = 0; i < 5; i++) push($urandom);
        s_ready = 1'b1;
        bus_write(2'd2, 32'h3);
        s_ready = 1'b0;
        bus_read(2'd1);
        bus_read(2'd2);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            s_ready = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2, 3: push($urandom);
                4, 5:       bus_read(2'($urandom_range(0, 3)));
                6:          bus_write(2'd1, $urandom);
                7: begin
                    d = ($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0;
                    if ($urandom_range(0, 7) == 0) d = d | 32'h2;
                    bus_write(2'd2, d | ($urandom & 32'hFFFF_FFFC));
                end
                8:          bus_write(2'd3, $urandom);
                default:    idle(1);
            endcase
        end
        s_ready = 1'b0;

        // Asynchronous reset mid-operation
        bus_write(2'd2, 32'h3);
        bus_write(2'd3, 32'd8);
        for (int i = 0; i < 8; i++) push($urandom);
        idle(1);
        bus_read(2'd1);
        #1;
        mon_en = 1'b0;
        check("pre_reset_s_valid", s_valid, 1'b1);
        check("pre_reset_irq", irq, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rdata", rdata, 32'h0);
        check("async_s_valid", s_valid, 1'b0);
        check("async_s_data", s_data, '0);
        check("async_irq", irq, 1'b0);
        model_reset();
        @(posedge ck);
        #2;
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge ck);
        #1;
        bus_read(2'd1);
        idle(3);

        mon_en = 1'b0;
        check("read_responses_left", 32'(rd_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
